// File: rtl/display_pkg.sv
// Shared display codes and message encodings for the scan driver and the segment decoder.
// Also holds the small helpers used by the BCD converter and the message loader.
package display_pkg;

  localparam logic [4:0] CODE_BLANK     = 5'd30;
  localparam logic [4:0] CODE_DP_OFFSET = 5'd11;
  localparam logic [4:0] CODE_F         = 5'd21;
  localparam logic [4:0] CODE_A         = 5'd22;
  localparam logic [4:0] CODE_I         = 5'd23;
  localparam logic [4:0] CODE_L         = 5'd24;
  localparam logic [4:0] CODE_N         = 5'd25;
  localparam logic [4:0] CODE_U         = 5'd26;
  localparam logic [4:0] CODE_E         = 5'd27;
  localparam logic [4:0] CODE_D         = 5'd28;

  localparam int BIN_WIDTH = 14;

  typedef enum logic [1:0] {
    MSG_NUM   = 2'd0,
    MSG_FAIL  = 2'd1,
    MSG_END   = 2'd2,
    MSG_BLANK = 2'd3
  } msg_sel_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } conv_state_t;

  // Four digit codes packed as {digit3, digit2, digit1, digit0}.
  function automatic logic [19:0] msg_digits(input msg_sel_t sel);
    case (sel)
      MSG_FAIL: return {CODE_F, CODE_A, CODE_I, CODE_L};
      MSG_END:  return {CODE_BLANK, CODE_E, CODE_N, CODE_D};
      default:  return {4{CODE_BLANK}};
    endcase
  endfunction

  // Add 3 to every BCD nibble that is 5 or more, ahead of the next left shift.
  function automatic logic [15:0] bcd_adjust(input logic [15:0] bcd);
    logic [15:0] r;
    r = bcd;
    for (int i = 0; i < 4; i++) begin
      if (bcd[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter, one input bit per clock.
// state  | meaning
// IDLE   | waiting for start, result registers hold last conversion
// SHIFT  | 14 adjust-and-shift iterations, counted by bit_cnt
// COMMIT | result valid, done high for one cycle
module bin2bcd_seq
  import display_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [BIN_WIDTH-1:0] bin,
  output logic                 busy,
  output logic                 done,
  output logic [3:0]           thousands,
  output logic [3:0]           hundreds,
  output logic [3:0]           tens,
  output logic [3:0]           units
);

  conv_state_t          state;
  logic [3:0]           bit_cnt;
  logic [BIN_WIDTH-1:0] shreg;
  logic [15:0]          bcd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      bit_cnt <= 4'd0;
      shreg   <= '0;
      bcd     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            shreg   <= bin;
            bcd     <= '0;
            bit_cnt <= 4'd0;
            busy    <= 1'b1;
            state   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          {bcd, shreg} <= {bcd_adjust(bcd), shreg} << 1;
          bit_cnt      <= bit_cnt + 4'd1;
          if (bit_cnt == 4'(BIN_WIDTH - 1)) begin
            done  <= 1'b1;
            state <= ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          bit_cnt <= 4'd0;
          state   <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign thousands = bcd[15:12];
  assign hundreds  = bcd[11:8];
  assign tens      = bcd[7:4];
  assign units     = bcd[3:0];

endmodule

// File: rtl/display_scan_driver.sv
// Four-digit multiplexed display driver: loads a clamped number or a fixed message
// into digit registers and scans them out one digit per refresh period.
module display_scan_driver
  import display_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int MAX_VAL     = 9999
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [BIN_WIDTH-1:0] value,
  input  logic [1:0]           msg_sel,
  output logic [4:0]           code,
  output logic [3:0]           an,
  output logic                 busy
);

  localparam int                   CW        = $clog2(REFRESH_DIV + 1);
  localparam logic [BIN_WIDTH-1:0] MAX_CLAMP = BIN_WIDTH'(MAX_VAL);

  msg_sel_t             msg;
  logic                 load_ok;
  logic                 conv_start;
  logic [BIN_WIDTH-1:0] value_clamped;
  logic                 conv_done;
  logic [3:0]           bcd_th, bcd_hu, bcd_te, bcd_un;
  logic [19:0]          msg_codes;
  logic [4:0]           digit_q [4];

  assign msg           = msg_sel_t'(msg_sel);
  assign load_ok       = load && !busy;
  assign conv_start    = load_ok && (msg == MSG_NUM);
  assign value_clamped = (value > MAX_CLAMP) ? MAX_CLAMP : value;
  assign msg_codes     = msg_digits(msg);

  bin2bcd_seq u_bin2bcd (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (conv_start),
    .bin       (value_clamped),
    .busy      (busy),
    .done      (conv_done),
    .thousands (bcd_th),
    .hundreds  (bcd_hu),
    .tens      (bcd_te),
    .units     (bcd_un)
  );

  // Digits change only on a message load or at commit, so partial results never show.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) digit_q[i] <= CODE_BLANK;
    end else if (load_ok && (msg != MSG_NUM)) begin
      digit_q[3] <= msg_codes[19:15];
      digit_q[2] <= msg_codes[14:10];
      digit_q[1] <= msg_codes[9:5];
      digit_q[0] <= msg_codes[4:0];
    end else if (conv_done) begin
      digit_q[3] <= {1'b0, bcd_th} + CODE_DP_OFFSET;
      digit_q[2] <= {1'b0, bcd_hu};
      digit_q[1] <= {1'b0, bcd_te};
      digit_q[0] <= {1'b0, bcd_un};
    end
  end

  logic [CW-1:0] refresh_cnt;
  logic [1:0]    scan_idx;
  logic [1:0]    next_idx;
  logic          scan_on;
  logic          next_on;
  logic          wrap;

  assign wrap     = (refresh_cnt == CW'(REFRESH_DIV - 1));
  assign next_idx = (wrap && scan_on) ? scan_idx + 2'd1 : scan_idx;
  // The first wrap after reset only enables the anodes, starting at index 0.
  assign next_on  = scan_on || wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      refresh_cnt <= '0;
      scan_idx    <= 2'd0;
      scan_on     <= 1'b0;
      an          <= 4'b1111;
      code        <= CODE_BLANK;
    end else begin
      refresh_cnt <= wrap ? '0 : refresh_cnt + CW'(1);
      scan_idx    <= next_idx;
      scan_on     <= next_on;
      an          <= next_on ? ~(4'b0001 << next_idx) : 4'b1111;
      code        <= next_on ? digit_q[next_idx] : CODE_BLANK;
    end
  end

endmodule

// File: tb/tb_display_scan_driver.sv
// Directed self-checking bench for display_scan_driver with a short refresh period.
module tb_display_scan_driver;

  logic        clk;
  logic        rst_n;
  logic        load;
  logic [13:0] value;
  logic [1:0]  msg_sel;
  logic [4:0]  code;
  logic [3:0]  an;
  logic        busy;

  int checks = 0;
  int errors = 0;

  display_scan_driver #(.REFRESH_DIV(4), .MAX_VAL(9999)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .value   (value),
    .msg_sel (msg_sel),
    .code    (code),
    .an      (an),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  msg;
    logic [13:0] val;
    logic [19:0] exp_d;
    int          exp_busy;
  } vec_t;

  vec_t vecs [11];

  function automatic logic [19:0] dig(input int d3, input int d2, input int d1, input int d0);
    return {5'(d3), 5'(d2), 5'(d1), 5'(d0)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic apply_load(input logic [1:0] m, input logic [13:0] v);
    @(negedge clk);
    load    = 1'b1;
    msg_sel = m;
    value   = v;
    @(negedge clk);
    load    = 1'b0;
  endtask

  // Counts busy-high samples starting at the current negedge.
  task automatic busy_len(output int n);
    n = 0;
    while (busy && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic capture_digits(output logic [19:0] d, output bit ok);
    logic [3:0] seen;
    seen = 4'h0;
    d    = '0;
    for (int i = 0; i < 64 && seen != 4'hf; i++) begin
      @(negedge clk);
      case (an)
        4'b1110: begin d[4:0]   = code; seen[0] = 1'b1; end
        4'b1101: begin d[9:5]   = code; seen[1] = 1'b1; end
        4'b1011: begin d[14:10] = code; seen[2] = 1'b1; end
        4'b0111: begin d[19:15] = code; seen[3] = 1'b1; end
        default: ;
      endcase
    end
    ok = (seen == 4'hf);
  endtask

  task automatic check_digits(input string name, input logic [19:0] exp);
    logic [19:0] d;
    bit ok;
    capture_digits(d, ok);
    check({name, "_scan_seen"}, 32'(ok), 32'd1);
    check(name, 32'(d), 32'(exp));
  endtask

  initial begin
    int n;
    logic [3:0] exp_an;

    vecs[0]  = '{2'd0, 14'd1234,  dig(12, 2, 3, 4),    15};
    vecs[1]  = '{2'd0, 14'd12000, dig(20, 9, 9, 9),    15};
    vecs[2]  = '{2'd0, 14'd0,     dig(11, 0, 0, 0),    15};
    vecs[3]  = '{2'd1, 14'd777,   dig(21, 22, 23, 24), 0};
    vecs[4]  = '{2'd2, 14'd777,   dig(30, 27, 25, 28), 0};
    vecs[5]  = '{2'd3, 14'd4321,  dig(30, 30, 30, 30), 0};
    vecs[6]  = '{2'd0, 14'd9999,  dig(20, 9, 9, 9),    15};
    vecs[7]  = '{2'd0, 14'd10000, dig(20, 9, 9, 9),    15};
    vecs[8]  = '{2'd0, 14'd16383, dig(20, 9, 9, 9),    15};
    vecs[9]  = '{2'd0, 14'd907,   dig(11, 9, 0, 7),    15};
    vecs[10] = '{2'd0, 14'd4090,  dig(15, 0, 9, 0),    15};

    rst_n   = 1'b0;
    load    = 1'b0;
    value   = '0;
    msg_sel = 2'd0;

    repeat (3) @(negedge clk);
    check("reset_code", 32'(code), 32'd30);
    check("reset_an",   32'(an),   32'hf);
    check("reset_busy", 32'(busy), 32'd0);

    // Release at a negedge; posedge n after release is sampled at the next negedge.
    rst_n = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      exp_an = (k < 4) ? 4'b1111 : ~(4'b0001 << (((k - 4) / 4) % 4));
      check($sformatf("scan_an_%0d", k), 32'(an), 32'(exp_an));
    end

    for (int i = 0; i < 11; i++) begin
      apply_load(vecs[i].msg, vecs[i].val);
      busy_len(n);
      check($sformatf("vec%0d_busy_len", i), 32'(n), 32'(vecs[i].exp_busy));
      check_digits($sformatf("vec%0d_digits", i), vecs[i].exp_d);
    end

    // Second load five cycles into a conversion must be dropped.
    apply_load(2'd0, 14'd1234);
    check("ign_busy_start", 32'(busy), 32'd1);
    repeat (4) @(negedge clk);
    load = 1'b1; value = 14'd5678; msg_sel = 2'd0;
    @(negedge clk);
    load = 1'b0;
    busy_len(n);
    check("ign_busy_rest", 32'(n), 32'd10);
    check_digits("ign_digits", dig(12, 2, 3, 4));

    // A message load during a conversion is also dropped.
    apply_load(2'd0, 14'd42);
    @(negedge clk);
    load = 1'b1; msg_sel = 2'd1;
    @(negedge clk);
    load = 1'b0;
    busy_len(n);
    check("ign_msg_busy_rest", 32'(n), 32'd13);
    check_digits("ign_msg_digits", dig(11, 0, 4, 2));

    // Reset at cycle 7 of a conversion aborts it and blanks everything.
    apply_load(2'd1, 14'd0);
    apply_load(2'd0, 14'd1234);
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_an",   32'(an),   32'hf);
    check("abort_code", 32'(code), 32'd30);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("abort_busy_later", 32'(busy), 32'd0);
    check_digits("abort_digits", dig(30, 30, 30, 30));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
